alu_rr_scheduler: RTL and testbench

Shares one instance of the team's 6-bit combinational `alu` between NUM_REQ requesters. Each requester issues an operation (A, B, sel) with a valid/ready handshake. A round-robin arbiter grants one request at a time, latches its operands, evaluates them through the ALU, and returns a registered, requester-tagged result through a valid/ready response channel. The block sits between the control front-ends and the ALU datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_rr_scheduler_if.sv | 35 +++
 rtl/alu.sv | 27 ++
 rtl/alu_rr_scheduler_rr_arbiter.sv | 40 ++++
 rtl/alu_rr_scheduler.sv | 119 +++++++++++
 tb/tb_alu_rr_scheduler.sv | 211 +++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the round-robin scheduler that shares it:
// datapath widths, opcode encoding, scheduler state encoding and an
// opcode-legality helper.
package alu_pkg;

    localparam int WIDTH = 6;
    localparam int SEL_W = 3;

    typedef enum logic [SEL_W-1:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        EQ   = 3'b100,
        GT   = 3'b101,
        LT   = 3'b110,
        ZERO = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } sched_state_e;

    // 3'b010 and 3'b011 have no ALU function behind them.
    function automatic logic op_supported(input logic [SEL_W-1:0] sel);
        return !((sel == 3'b010) || (sel == 3'b011));
    endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the requester front-ends and the scheduler.
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b/req_sel : per-requester operands and opcode
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_data/rsp_err : tagged result
// master = requester/consumer side, slave = scheduler side.
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 6,
    parameter int SEL_W   = 3
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0][SEL_W-1:0] req_sel;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_W-1:0]               rsp_id;
    logic [WIDTH-1:0]              rsp_data;
    logic                          rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu.sv
// Team 6-bit combinational ALU.
//   a_i, b_i : operands
//   sel_i    : opcode (alu_op_e)
//   c_o      : result; compares give 0/1, unsupported opcodes give 0
module alu
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [WIDTH-1:0] c_o
);

    always_comb begin
        c_o = '0;
        case (sel_i)
            ADD:     c_o = a_i + b_i;
            SUB:     c_o = a_i - b_i;
            EQ:      c_o[0] = (a_i == b_i);
            GT:      c_o[0] = ($signed(a_i) > $signed(b_i));
            LT:      c_o[0] = ($signed(a_i) < $signed(b_i));
            ZERO:    c_o[0] = (a_i == '0);
            default: c_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req_valid_i  : pending requests
//   last_grant_i : requester granted most recently (search starts one above)
//   grant_o      : one-hot grant (zero when nothing pending)
//   winner_o     : index of the granted requester
//   found_o      : at least one request pending
module alu_rr_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    winner_o,
    output logic               found_o
);

    localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] sum;

    // Walk last+1 .. last+NUM_REQ; the extra bit lets a single subtract
    // implement the wrap for non-power-of-two NUM_REQ.
    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found_o  = 1'b0;
        sum      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            sum = {1'b0, last_grant_i} + (ID_W+1)'(k);
            if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
            if (!found_o && req_valid_i[sum[ID_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = sum[ID_W-1:0];
            end
        end
        grant_o[winner_o] = found_o;
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU among NUM_REQ requesters. IDLE picks a winner round-robin
// and latches its operation, EXEC registers the ALU result, RESP holds the
// tagged result until the consumer takes it.
//   clk, reset : clock, synchronous active-high reset
//   sched_if   : request/response bundle (slave side)
module alu_rr_scheduler
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = alu_pkg::WIDTH,
    parameter int SEL_W   = alu_pkg::SEL_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    alu_rr_scheduler_if.slave  sched_if
);
    import alu_pkg::*;

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [SEL_W-1:0] op_sel_q, op_sel_d;
    logic [ID_W-1:0]  op_id_q, op_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic [NUM_REQ-1:0] req_ready_c;
    logic [WIDTH-1:0]   alu_c;

    alu_rr_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_valid_i  (sched_if.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .winner_o     (winner),
        .found_o      (found)
    );

    // The ALU sees only latched operands so requester inputs can move freely
    // once accepted.
    alu u_alu (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sel_i (op_sel_q),
        .c_o   (alu_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ-1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            op_id_q      <= '0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_sel_q     <= op_sel_d;
            op_id_q      <= op_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        op_id_d      = op_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        req_ready_c  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c  = grant;
                    op_a_d       = sched_if.req_a[winner];
                    op_b_d       = sched_if.req_b[winner];
                    op_sel_d     = sched_if.req_sel[winner];
                    op_id_d      = winner;
                    last_grant_d = winner;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                rsp_id_d   = op_id_q;
                rsp_err_d  = !op_supported(op_sel_q);
                rsp_data_d = op_supported(op_sel_q) ? alu_c : '0;
                state_d    = RESP;
            end
            RESP: begin
                if (sched_if.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // No accept while reset is held: the transfer would be thrown away and
    // the requester would wrongly believe it had been taken.
    assign sched_if.req_ready = reset ? '0 : req_ready_c;
    assign sched_if.rsp_valid = (state_q == RESP);
    assign sched_if.rsp_data  = rsp_data_q;
    assign sched_if.rsp_id    = rsp_id_q;
    assign sched_if.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;
    import alu_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NUM_REQ(N), .WIDTH(6), .SEL_W(3)) bus();

    alu_rr_scheduler #(.NUM_REQ(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .sched_if (bus)
    );

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic init_bus();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Issue one request and follow it to its response; returns observations.
    task automatic do_op(input int id, input logic [5:0] a, input logic [5:0] b,
                         input logic [2:0] sel, output logic [N-1:0] rdy,
                         output int lat, output logic [1:0] rid,
                         output logic [5:0] rdata, output logic rerr);
        int waits = 0;
        bus.req_a[id]     = a;
        bus.req_b[id]     = b;
        bus.req_sel[id]   = sel;
        bus.req_valid[id] = 1'b1;
        #1;
        while (bus.req_ready == '0 && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        rdy = bus.req_ready;
        @(posedge clk); #1;
        bus.req_valid[id] = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rid   = bus.rsp_id;
        rdata = bus.rsp_data;
        rerr  = bus.rsp_err;
    endtask

    task automatic test_reset();
        init_bus();
        do_reset();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 6'd0) begin failures++; $display("FAIL reset_rsp_data got=%0d want=0", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
    endtask

    task automatic test_add();
        logic [N-1:0] rdy; int lat; logic [1:0] rid; logic [5:0] rd; logic re;
        do_op(0, 6'd5, 6'd10, ADD, rdy, lat, rid, rd, re);
        checks++; if (rdy !== 4'b0001) begin failures++; $display("FAIL add_grant got=%b want=0001", rdy); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d want=2", lat); end
        checks++; if (rid !== 2'd0) begin failures++; $display("FAIL add_id got=%0d want=0", rid); end
        checks++; if (rd !== 6'd15) begin failures++; $display("FAIL add_data got=%0d want=15", rd); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL add_err got=%b want=0", re); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL add_ready_pulse got=%b want=0000", bus.req_ready); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL add_rsp_drop got=%b want=0", bus.rsp_valid); end
    endtask

    // All requesters in mask issue 16-1; grants must follow ord[0..cnt-1].
    task automatic rr_round(input logic [N-1:0] mask, input int o0, input int o1,
                            input int o2, input int o3, input int cnt);
        int ord[4];
        ord = '{o0, o1, o2, o3};
        for (int i = 0; i < N; i++) begin
            bus.req_a[i]   = 6'd16;
            bus.req_b[i]   = 6'd1;
            bus.req_sel[i] = SUB;
        end
        bus.req_valid = mask;
        #1;
        for (int k = 0; k < cnt; k++) begin
            int w = 0;
            logic [N-1:0] want;
            want = '0;
            want[ord[k]] = 1'b1;
            while (bus.req_ready == '0 && w < 8) begin @(posedge clk); #1; w++; end
            checks++; if (bus.req_ready !== want) begin failures++; $display("FAIL rr_grant_%0d got=%b want=%b", k, bus.req_ready, want); end
            @(posedge clk); #1;
            bus.req_valid[ord[k]] = 1'b0;
            w = 0;
            while (!bus.rsp_valid && w < 8) begin @(posedge clk); #1; w++; end
            checks++; if (bus.rsp_id !== 2'(ord[k])) begin failures++; $display("FAIL rr_id_%0d got=%0d want=%0d", k, bus.rsp_id, ord[k]); end
            checks++; if (bus.rsp_data !== 6'd15) begin failures++; $display("FAIL rr_data_%0d got=%0d want=15", k, bus.rsp_data); end
        end
    endtask

    task automatic test_round_robin();
        init_bus();
        do_reset();
        rr_round(4'b1011, 0, 1, 3, 0, 3);
        rr_round(4'b1111, 0, 1, 2, 3, 4);
    endtask

    task automatic test_backpressure();
        logic [N-1:0] rdy; int lat; logic [1:0] rid; logic [5:0] rd; logic re;
        init_bus();
        do_reset();
        bus.rsp_ready = 1'b0;
        // -15 in 6 bits is 6'h31
        do_op(2, 6'h31, 6'h31, EQ, rdy, lat, rid, rd, re);
        checks++; if (rdy !== 4'b0100) begin failures++; $display("FAIL bp_grant got=%b want=0100", rdy); end
        checks++; if (rd !== 6'd1) begin failures++; $display("FAIL bp_data got=%0d want=1", rd); end
        bus.req_a[1] = 6'd1; bus.req_b[1] = 6'd1; bus.req_sel[1] = ADD;
        bus.req_valid[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid_%0d got=%b want=1", c, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== 6'd1 || bus.rsp_id !== 2'd2) begin failures++; $display("FAIL bp_hold_rsp_%0d got=%0d/%0d want=1/2", c, bus.rsp_data, bus.rsp_id); end
            checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready_%0d got=%b want=0000", c, bus.req_ready); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b want=0", bus.rsp_valid); end
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_next_grant got=%b want=0010", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 6'd2) begin
            failures++; $display("FAIL bp_next_rsp got=v%b id%0d d%0d want=v1 id1 d2", bus.rsp_valid, bus.rsp_id, bus.rsp_data);
        end
    endtask

    task automatic test_unsupported();
        logic [N-1:0] rdy; int lat; logic [1:0] rid; logic [5:0] rd; logic re;
        do_op(1, 6'd7, 6'd3, 3'b010, rdy, lat, rid, rd, re);
        checks++; if (rid !== 2'd1) begin failures++; $display("FAIL unsup_id got=%0d want=1", rid); end
        checks++; if (rd !== 6'd0) begin failures++; $display("FAIL unsup_data got=%0d want=0", rd); end
        checks++; if (re !== 1'b1) begin failures++; $display("FAIL unsup_err got=%b want=1", re); end
        do_op(1, 6'h3D, 6'h36, GT, rdy, lat, rid, rd, re);  // -3 > -10
        checks++; if (rd !== 6'd1) begin failures++; $display("FAIL gt_data got=%0d want=1", rd); end
        checks++; if (re !== 1'b0) begin failures++; $display("FAIL gt_err got=%b want=0", re); end
    endtask

    task automatic test_signed_zero();
        logic [N-1:0] rdy; int lat; logic [1:0] rid; logic [5:0] rd; logic re;
        do_op(3, 6'd39, 6'd60, LT, rdy, lat, rid, rd, re);  // -25 < -4
        checks++; if (rd !== 6'd1 || rid !== 2'd3) begin failures++; $display("FAIL lt_data got=%0d/%0d want=1/3", rd, rid); end
        do_op(0, 6'd0, 6'd5, ZERO, rdy, lat, rid, rd, re);
        checks++; if (rd !== 6'd1) begin failures++; $display("FAIL zero_true got=%0d want=1", rd); end
        do_op(0, 6'd1, 6'd0, ZERO, rdy, lat, rid, rd, re);
        checks++; if (rd !== 6'd0) begin failures++; $display("FAIL zero_false got=%0d want=0", rd); end
        do_op(2, 6'd31, 6'd15, ADD, rdy, lat, rid, rd, re);
        checks++; if (rd !== 6'b101110) begin failures++; $display("FAIL add_wide got=%b want=101110", rd); end
    endtask

    task automatic test_reset_mid_resp();
        logic [N-1:0] rdy; int lat; logic [1:0] rid; logic [5:0] rd; logic re;
        bus.rsp_ready = 1'b0;
        do_op(2, 6'd1, 6'd2, ADD, rdy, lat, rid, rd, re);
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid got=%b want=1", bus.rsp_valid); end
        for (int i = 0; i < N; i++) begin
            bus.req_a[i] = 6'd1; bus.req_b[i] = 6'd1; bus.req_sel[i] = ADD;
        end
        bus.req_valid = 4'b1111;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
        reset = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rst_first_grant got=%b want=0001", bus.req_ready); end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_round_robin();
        test_backpressure();
        test_unsupported();
        test_signed_zero();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
